// File: rtl/pico_pkg.sv
// Shared definitions for the pico MIPS sequential decoder: opcode and ALU
// codes, FSM state encoding, the control-output bundle and a small helper.
package pico_pkg;

    localparam int PICO_OPCODE_W = 6;
    localparam int PICO_ALU_W    = 3;

    // Instruction opcodes
    localparam logic [PICO_OPCODE_W-1:0] NOP  = 6'h00;
    localparam logic [PICO_OPCODE_W-1:0] ADD  = 6'h01;
    localparam logic [PICO_OPCODE_W-1:0] ADDI = 6'h02;
    localparam logic [PICO_OPCODE_W-1:0] SUB  = 6'h03;
    localparam logic [PICO_OPCODE_W-1:0] SUBI = 6'h04;
    localparam logic [PICO_OPCODE_W-1:0] MLT  = 6'h05;
    localparam logic [PICO_OPCODE_W-1:0] MLTI = 6'h06;
    localparam logic [PICO_OPCODE_W-1:0] BEQ  = 6'h07;
    localparam logic [PICO_OPCODE_W-1:0] JMP  = 6'h08;
    localparam logic [PICO_OPCODE_W-1:0] LD   = 6'h09;
    localparam logic [PICO_OPCODE_W-1:0] ST   = 6'h0A;

    // ALU function codes
    localparam logic [PICO_ALU_W-1:0] RADD = 3'b010;
    localparam logic [PICO_ALU_W-1:0] RSUB = 3'b110;
    localparam logic [PICO_ALU_W-1:0] RMLT = 3'b100;

    typedef enum logic [1:0] {
        RUN,
        MULT_WAIT,
        LOAD_WAIT
    } dec_state_t;

    // How the sequencer has to treat a decoded instruction
    typedef enum logic [1:0] {
        CLS_SINGLE,
        CLS_BRANCH,
        CLS_MULT,
        CLS_LOAD
    } op_class_t;

    typedef struct packed {
        logic [PICO_ALU_W-1:0] alu_func;
        logic                  reg_write;
        logic                  immediate;
        logic                  pc_rel_branch;
        logic                  read_in;
        logic                  write_out;
        logic                  illegal;
    } ctrl_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// Fetch-to-decoder handshake plus the decoded control lines toward the
// ALU, register file and memory ports.
interface seq_decoder_if #(
    parameter int OPCODE_W = 6,
    parameter int ALU_W    = 3
);
    logic                instr_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                ZF;
    logic                instr_ready;
    logic [ALU_W-1:0]    alu_func;
    logic                reg_write;
    logic                immediate;
    logic                pc_rel_branch;
    logic                read_in;
    logic                write_out;
    logic                illegal;

    modport master (
        output instr_valid, opcode, ZF,
        input  instr_ready, alu_func, reg_write, immediate,
               pc_rel_branch, read_in, write_out, illegal
    );

    modport slave (
        input  instr_valid, opcode, ZF,
        output instr_ready, alu_func, reg_write, immediate,
               pc_rel_branch, read_in, write_out, illegal
    );
endinterface

// File: rtl/seq_decoder_decode_rom.sv
// Pure combinational opcode table: single-cycle control values, the class
// that tells the sequencer how long the op lasts, and a legal bit.
module decode_rom
    import pico_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output op_class_t           o_class,
    output logic                o_aluUsed,
    output logic                o_legal
);

    // Table lookup; opcodes compare at full width so stray upper bits miss
    always_comb begin
        o_ctrl          = '0;
        o_ctrl.alu_func = RADD;
        o_class         = CLS_SINGLE;
        o_aluUsed       = 1'b0;
        o_legal         = 1'b1;
        case (i_opcode)
            OPCODE_W'(NOP): ;
            OPCODE_W'(ADD): begin
                o_ctrl.alu_func  = RADD;
                o_ctrl.reg_write = 1'b1;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(ADDI): begin
                o_ctrl.alu_func  = RADD;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.immediate = 1'b1;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(SUB): begin
                o_ctrl.alu_func  = RSUB;
                o_ctrl.reg_write = 1'b1;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(SUBI): begin
                o_ctrl.alu_func  = RSUB;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.immediate = 1'b1;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(MLT): begin
                o_ctrl.alu_func  = RMLT;
                o_ctrl.reg_write = 1'b1;
                o_class          = CLS_MULT;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(MLTI): begin
                o_ctrl.alu_func  = RMLT;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.immediate = 1'b1;
                o_class          = CLS_MULT;
                o_aluUsed        = 1'b1;
            end
            OPCODE_W'(BEQ): begin
                o_ctrl.pc_rel_branch = 1'b1;
                o_class              = CLS_BRANCH;
            end
            OPCODE_W'(JMP): begin
                o_ctrl.pc_rel_branch = 1'b1;
            end
            OPCODE_W'(LD): begin
                o_ctrl.read_in   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_class          = CLS_LOAD;
            end
            OPCODE_W'(ST): begin
                o_ctrl.write_out = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered, stall-capable instruction decoder. Multi-cycle MLT/MLTI and
// LD hold their control lines while back-pressuring fetch; BEQ resolves on
// a forwarded zero flag when the previous op is still writing back.
module seq_decoder
    import pico_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int ALU_W      = 3,
    parameter int MLT_CYCLES = 3,
    parameter int LD_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    seq_decoder_if.slave  bus
);

    localparam int MAX_CYC = max_int(MLT_CYCLES, LD_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    dec_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_zfQ;
    ctrl_t            r_ctrl;

    ctrl_t            w_romCtrl;
    op_class_t        w_romClass;
    logic             w_romAluUsed;
    logic             w_romLegal;
    logic             w_ready;
    logic             w_accept;
    logic             w_effZf;
    ctrl_t            w_acceptCtrl;
    ctrl_t            w_idleCtrl;

    decode_rom #(
        .OPCODE_W (OPCODE_W)
    ) u_rom (
        .i_opcode  (bus.opcode),
        .o_ctrl    (w_romCtrl),
        .o_class   (w_romClass),
        .o_aluUsed (w_romAluUsed),
        .o_legal   (w_romLegal)
    );

    assign w_ready  = (r_state == RUN);
    assign w_accept = bus.instr_valid && w_ready;
    assign w_effZf  = r_ctrl.reg_write ? bus.ZF : r_zfQ;

    // Shape the first output cycle of an accepted op and the idle cycle
    always_comb begin
        w_acceptCtrl         = w_romCtrl;
        w_acceptCtrl.illegal = !w_romLegal;
        if (!w_romAluUsed) begin
            w_acceptCtrl.alu_func = r_ctrl.alu_func;
        end
        if (w_romClass == CLS_BRANCH) begin
            w_acceptCtrl.pc_rel_branch = w_effZf;
        end
        if ((w_romClass == CLS_MULT) && (MLT_CYCLES > 1)) begin
            w_acceptCtrl.reg_write = 1'b0;
        end
        if ((w_romClass == CLS_LOAD) && (LD_CYCLES > 1)) begin
            w_acceptCtrl.reg_write = 1'b0;
        end

        w_idleCtrl          = '0;
        w_idleCtrl.alu_func = r_ctrl.alu_func;
    end

    // Sequencer FSM: output registers, wait counter and the zero-flag copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= RUN;
            r_count         <= '0;
            r_zfQ           <= 1'b0;
            r_ctrl          <= '0;
            r_ctrl.alu_func <= RADD;
        end else begin
            if (r_ctrl.reg_write) begin
                r_zfQ <= bus.ZF;
            end
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_ctrl <= w_acceptCtrl;
                        if ((w_romClass == CLS_MULT) && (MLT_CYCLES > 1)) begin
                            r_state <= MULT_WAIT;
                            r_count <= CNT_W'(MLT_CYCLES - 1);
                        end else if ((w_romClass == CLS_LOAD) && (LD_CYCLES > 1)) begin
                            r_state <= LOAD_WAIT;
                            r_count <= CNT_W'(LD_CYCLES - 1);
                        end
                    end else begin
                        r_ctrl <= w_idleCtrl;
                    end
                end
                MULT_WAIT, LOAD_WAIT: begin
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state          <= RUN;
                        r_ctrl.reg_write <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_ctrl  <= w_idleCtrl;
                end
            endcase
        end
    end

    assign bus.instr_ready   = w_ready;
    assign bus.alu_func      = ALU_W'(r_ctrl.alu_func);
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.immediate     = r_ctrl.immediate;
    assign bus.pc_rel_branch = r_ctrl.pc_rel_branch;
    assign bus.read_in       = r_ctrl.read_in;
    assign bus.write_out     = r_ctrl.write_out;
    assign bus.illegal       = r_ctrl.illegal;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: directed scenarios followed by random traffic,
// all checked against a per-cycle queue model of the expected outputs.
module tb_seq_decoder;
    import pico_pkg::*;

    localparam int MLT_C = 3;
    localparam int LD_C  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_decoder_if #(.OPCODE_W(6), .ALU_W(3)) bus ();

    seq_decoder #(
        .OPCODE_W   (6),
        .ALU_W      (3),
        .MLT_CYCLES (MLT_C),
        .LD_CYCLES  (LD_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] alu;
        logic       rw;
        logic       imm;
        logic       pc;
        logic       rd;
        logic       wr;
        logic       ill;
    } frame_t;

    frame_t q[$];
    frame_t cur;
    logic   zfq;
    int     total = 0;
    int     bad   = 0;

    logic [5:0] ops [13] = '{NOP, ADD, ADDI, SUB, SUBI, MLT, MLTI, BEQ,
                             JMP, LD, ST, 6'h3F, 6'h2A};

    function automatic frame_t idleFrame(input logic [2:0] alu);
        frame_t f;
        f.alu = alu;
        f.rw  = 1'b0;
        f.imm = 1'b0;
        f.pc  = 1'b0;
        f.rd  = 1'b0;
        f.wr  = 1'b0;
        f.ill = 1'b0;
        return f;
    endfunction

    task automatic modelReset();
        cur = idleFrame(RADD);
        q.delete();
        zfq = 1'b0;
    endtask

    task automatic chk(input string tag, input string sig,
                       input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, sig, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk(tag, "alu_func",      8'(bus.alu_func),      8'(cur.alu));
        chk(tag, "reg_write",     8'(bus.reg_write),     8'(cur.rw));
        chk(tag, "immediate",     8'(bus.immediate),     8'(cur.imm));
        chk(tag, "pc_rel_branch", 8'(bus.pc_rel_branch), 8'(cur.pc));
        chk(tag, "read_in",       8'(bus.read_in),       8'(cur.rd));
        chk(tag, "write_out",     8'(bus.write_out),     8'(cur.wr));
        chk(tag, "illegal",       8'(bus.illegal),       8'(cur.ill));
        chk(tag, "instr_ready",   8'(bus.instr_ready),   8'(q.size() == 0));
    endtask

    // Queue one expected output frame per cycle the instruction occupies
    task automatic pushFrames(input logic [5:0] op, input logic effzf);
        frame_t f;
        f = idleFrame(cur.alu);
        case (op)
            NOP:  q.push_back(f);
            ADD:  begin f.alu = RADD; f.rw = 1'b1; q.push_back(f); end
            ADDI: begin f.alu = RADD; f.rw = 1'b1; f.imm = 1'b1; q.push_back(f); end
            SUB:  begin f.alu = RSUB; f.rw = 1'b1; q.push_back(f); end
            SUBI: begin f.alu = RSUB; f.rw = 1'b1; f.imm = 1'b1; q.push_back(f); end
            ST:   begin f.wr = 1'b1; q.push_back(f); end
            JMP:  begin f.pc = 1'b1; q.push_back(f); end
            BEQ:  begin f.pc = effzf; q.push_back(f); end
            MLT, MLTI: begin
                for (int k = 1; k <= MLT_C; k++) begin
                    f.alu = RMLT;
                    f.imm = (op == MLTI);
                    f.rw  = (k == MLT_C);
                    q.push_back(f);
                end
            end
            LD: begin
                for (int k = 1; k <= LD_C; k++) begin
                    f.rd = 1'b1;
                    f.rw = (k == LD_C);
                    q.push_back(f);
                end
            end
            default: begin f.ill = 1'b1; q.push_back(f); end
        endcase
    endtask

    // One clock cycle: drive, check at negedge, update model, cross posedge
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [5:0] op, input logic zf);
        logic effzf;
        bus.instr_valid = v;
        bus.opcode      = op;
        bus.ZF          = zf;
        @(negedge clk);
        checkOutput(tag);
        effzf = cur.rw ? zf : zfq;
        if (!reset && v && (q.size() == 0)) pushFrames(op, effzf);
        if (!reset && cur.rw) zfq = zf;
        @(posedge clk);
        #1;
        if (reset) modelReset();
        else if (q.size() > 0) cur = q.pop_front();
        else cur = idleFrame(cur.alu);
    endtask

    initial begin
        logic       v;
        logic [5:0] op;
        logic       zf;

        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = NOP;
        bus.ZF          = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        applyStimulus("reset_state", 1'b0, NOP, 1'b0);
        applyStimulus("reset_state", 1'b1, ADD, 1'b1);
        reset = 1'b0;

        // Back-to-back single-cycle ops
        applyStimulus("b2b_add",  1'b1, ADD,  1'b0);
        applyStimulus("b2b_subi", 1'b1, SUBI, 1'b0);
        applyStimulus("b2b_st",   1'b1, ST,   1'b0);
        applyStimulus("b2b_jmp",  1'b1, JMP,  1'b0);
        applyStimulus("b2b_tail", 1'b0, NOP,  1'b0);
        applyStimulus("b2b_tail", 1'b0, NOP,  1'b0);

        // MLTI followed by an ADD held valid through the stall
        applyStimulus("mlti",      1'b1, MLTI, 1'b0);
        applyStimulus("mlti_hold", 1'b1, ADD,  1'b0);
        applyStimulus("mlti_hold", 1'b1, ADD,  1'b0);
        applyStimulus("mlti_hold", 1'b1, ADD,  1'b1);
        applyStimulus("mlti_add",  1'b0, NOP,  1'b0);
        applyStimulus("mlti_tail", 1'b0, NOP,  1'b0);

        // Zero-flag forwarding and the registered copy
        applyStimulus("fwd_sub1",   1'b1, SUB, 1'b0);
        applyStimulus("fwd_beq1",   1'b1, BEQ, 1'b1);
        applyStimulus("fwd_nop1",   1'b1, NOP, 1'b0);
        applyStimulus("fwd_beq_q1", 1'b1, BEQ, 1'b0);
        applyStimulus("fwd_sub0",   1'b1, SUB, 1'b1);
        applyStimulus("fwd_beq0",   1'b1, BEQ, 1'b0);
        applyStimulus("fwd_nop0",   1'b1, NOP, 1'b1);
        applyStimulus("fwd_beq_q0", 1'b1, BEQ, 1'b1);
        applyStimulus("fwd_tail",   1'b0, NOP, 1'b1);
        applyStimulus("fwd_tail",   1'b0, NOP, 1'b0);

        // LD with opcodes presented during the stall
        applyStimulus("ld",         1'b1, LD,  1'b0);
        applyStimulus("ld_ignored", 1'b1, ST,  1'b1);
        applyStimulus("ld_last",    1'b1, ADD, 1'b0);
        applyStimulus("ld_tail",    1'b0, NOP, 1'b0);
        applyStimulus("ld_tail",    1'b0, NOP, 1'b0);

        // Unknown opcode
        applyStimulus("illegal",      1'b1, 6'h3F, 1'b0);
        applyStimulus("illegal_out",  1'b0, NOP,   1'b0);
        applyStimulus("illegal_tail", 1'b0, NOP,   1'b0);

        // Reset in the second output cycle of a MLT
        applyStimulus("mlt",     1'b1, MLT, 1'b0);
        applyStimulus("mlt_c1",  1'b0, NOP, 1'b1);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("mlt_async_reset");
        applyStimulus("mlt_in_reset", 1'b0, NOP, 1'b1);
        applyStimulus("mlt_in_reset", 1'b0, NOP, 1'b1);
        reset = 1'b0;
        applyStimulus("post_reset_idle", 1'b0, NOP, 1'b0);
        applyStimulus("post_reset_add",  1'b1, ADD, 1'b0);
        applyStimulus("post_reset_out",  1'b0, NOP, 1'b0);
        applyStimulus("post_reset_tail", 1'b0, NOP, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = ops[$urandom_range(0, 12)];
            zf = 1'($urandom_range(0, 1));
            applyStimulus("rand", v, op, zf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
